// File: rtl/cache_sram_array.sv
// cache_sram_array: parametrised dual-port tag/data storage for the cache controller.
// One read port with a 1-cycle registered result and rvalid_o strobe. One write port
// with a separate tag enable and per-byte data enables. After reset, the tag array is
// cleared one entry per cycle. init_busy_o stays high while that clear runs.
// Optional feature: define SRAM_BYPASS_EN to forward merged write data into a read of
// the same index in the same cycle. When it is undefined, such a read returns the
// pre-write contents.
// dbg_state exposes the sequencer state: 0 = RST, 1 = INIT, 2 = READY.
// Handshake: there is no backpressure. A request presented on a rising edge while
// init_busy_o is low is always accepted. A request presented while init_busy_o is
// high is dropped. rvalid_o pulses for one cycle, one edge after an accepted rden_i.
module cache_sram_array #(
   parameter int ADDR_W = 9,
   parameter int TAG_W  = 18,
   parameter int DATA_W = 512
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  init_busy_o,
   input  logic                  rden_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic                  rvalid_o,
   output logic [TAG_W-1:0]      rdata_tag_o,
   output logic [DATA_W-1:0]     rdata_data_o,
   input  logic                  wren_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic                  wtag_en_i,
   input  logic [DATA_W/8-1:0]   wbyte_en_i,
   input  logic [TAG_W-1:0]      wdata_tag_i,
   input  logic [DATA_W-1:0]     wdata_data_i,
   output logic [1:0]            dbg_state
);

   localparam int BE_W  = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_INIT  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   clr_cnt;
   logic                clearing;
   logic                accept;

   logic [TAG_W-1:0]    tag_array  [DEPTH];
   logic [DATA_W-1:0]   data_array [DEPTH];

   logic [TAG_W-1:0]    rd_tag;
   logic [DATA_W-1:0]   rd_data;
   logic [DATA_W-1:0]   wbit_mask;

   // The first rising edge out of reset already clears entry 0.
   // The clear therefore finishes exactly DEPTH edges after release.
   assign clearing  = rst_n && (state != ST_READY);
   assign accept    = rst_n && (state == ST_READY);
   assign dbg_state = state;

   // Sequencer: reset -> tag clear sweep -> ready; owns init_busy_o.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_RST;
         clr_cnt     <= '0;
         init_busy_o <= 1'b1;
      end else begin
         case (state)
            ST_RST, ST_INIT: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == CNT_LAST) begin
                  state       <= ST_READY;
                  init_busy_o <= 1'b0;
               end else begin
                  state <= ST_INIT;
               end
            end
            ST_READY: begin
               state <= ST_READY;
            end
            default: begin
               state       <= ST_RST;
               clr_cnt     <= '0;
               init_busy_o <= 1'b1;
            end
         endcase
      end
   end

   // Tag storage: cleared by the sweep, otherwise written when the tag enable is set.
   always_ff @(posedge clk) begin
      if (clearing) begin
         tag_array[clr_cnt] <= '0;
      end else if (accept && wren_i && wtag_en_i) begin
         tag_array[waddr_i] <= wdata_tag_i;
      end
   end

   // Data storage: byte-granular write.
   // The data array is never cleared, so an entry is undefined until it is written.
   always_ff @(posedge clk) begin
      if (accept && wren_i) begin
         for (int k = 0; k < BE_W; k++) begin
            if (wbyte_en_i[k]) begin
               data_array[waddr_i][8*k +: 8] <= wdata_data_i[8*k +: 8];
            end
         end
      end
   end

   // Read-side value: the stored entry, optionally merged with a same-index write.
   always_comb begin
      wbit_mask = '0;
      for (int k = 0; k < BE_W; k++) begin
         wbit_mask[8*k +: 8] = {8{wbyte_en_i[k]}};
      end
      rd_tag  = tag_array[raddr_i];
      rd_data = data_array[raddr_i];
`ifdef SRAM_BYPASS_EN
      if (wren_i && (waddr_i == raddr_i)) begin
         if (wtag_en_i) begin
            rd_tag = wdata_tag_i;
         end
         rd_data = (wdata_data_i & wbit_mask) | (rd_data & ~wbit_mask);
      end
`endif
   end

   // Registered read port: capture on an accepted read, otherwise hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid_o     <= 1'b0;
         rdata_tag_o  <= '0;
         rdata_data_o <= '0;
      end else begin
         rvalid_o <= accept && rden_i;
         if (accept && rden_i) begin
            rdata_tag_o  <= rd_tag;
            rdata_data_o <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_cache_sram_array.sv
// tb_cache_sram_array: directed bench for cache_sram_array (default parameters).
// A cycle-level behavioural model predicts busy, rvalid, tag and data on every cycle.
// A single compare process checks the DUT against that model.
// Literal expectations for the test-plan scenarios pin the model itself.
// Define SRAM_BYPASS_EN for both bench and RTL to exercise the forwarding build.
module tb_cache_sram_array;

   localparam int ADDR_W = 9;
   localparam int TAG_W  = 18;
   localparam int DATA_W = 512;
   localparam int BE_W   = DATA_W / 8;
   localparam int DEPTH  = 2 ** ADDR_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                rden, wren, wtag_en;
   logic [ADDR_W-1:0]   raddr, waddr;
   logic [BE_W-1:0]     wbe;
   logic [TAG_W-1:0]    wtag;
   logic [DATA_W-1:0]   wdata;
   logic                init_busy, rvalid;
   logic [TAG_W-1:0]    rdata_tag;
   logic [DATA_W-1:0]   rdata_data;
   logic [1:0]          dbg_state;

   cache_sram_array #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .init_busy_o(init_busy),
      .rden_i(rden), .raddr_i(raddr), .rvalid_o(rvalid),
      .rdata_tag_o(rdata_tag), .rdata_data_o(rdata_data),
      .wren_i(wren), .waddr_i(waddr), .wtag_en_i(wtag_en), .wbyte_en_i(wbe),
      .wdata_tag_i(wtag), .wdata_data_i(wdata), .dbg_state(dbg_state)
   );

   int checks = 0;
   int failures = 0;
   logic [TAG_W-1:0] exp_q[$];

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] expand(input logic [BE_W-1:0] m);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int k = 0; k < BE_W; k++) r[8*k +: 8] = {8{m[k]}};
      return r;
   endfunction

   // ---------------- behavioural model ----------------
   // The model counts edges since reset release; an access counts once DEPTH edges have passed.
   logic [TAG_W-1:0]  m_tag   [DEPTH];
   logic [DATA_W-1:0] m_data  [DEPTH];
   logic [BE_W-1:0]   m_known [DEPTH];
   bit                m_started = 0;
   int                rel;
   bit                m_busy, m_rvalid, acc;
   logic [TAG_W-1:0]  m_rtag;
   logic [DATA_W-1:0] m_rdata;
   logic [BE_W-1:0]   m_rknown;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_started = 1;
         rel = 0;
         m_busy = 1;
         m_rvalid = 0;
         m_rtag = '0;
         m_rdata = '0;
         m_rknown = '1;
         for (int i = 0; i < DEPTH; i++) m_known[i] = '0;
      end else begin
         acc = (rel >= DEPTH);
         if (rel < DEPTH) begin
            rel++;
            if (rel == DEPTH) for (int i = 0; i < DEPTH; i++) m_tag[i] = '0;
         end
         m_busy = (rel < DEPTH);
         m_rvalid = acc && rden;
         if (acc && rden) begin
            m_rtag = m_tag[raddr];
            m_rdata = m_data[raddr];
            m_rknown = m_known[raddr];
`ifdef SRAM_BYPASS_EN
            if (wren && waddr == raddr) begin
               if (wtag_en) m_rtag = wtag;
               for (int k = 0; k < BE_W; k++)
                  if (wbe[k]) begin
                     m_rdata[8*k +: 8] = wdata[8*k +: 8];
                     m_rknown[k] = 1'b1;
                  end
            end
`endif
         end
         if (acc && wren) begin
            if (wtag_en) m_tag[waddr] = wtag;
            for (int k = 0; k < BE_W; k++)
               if (wbe[k]) begin
                  m_data[waddr][8*k +: 8] = wdata[8*k +: 8];
                  m_known[waddr][k] = 1'b1;
               end
         end
      end
   end

   // Compare process: all outputs, every cycle, away from the active edge.
   always @(negedge clk) begin
      if (m_started) begin
         chk("busy", {{(DATA_W-1){1'b0}}, init_busy}, {{(DATA_W-1){1'b0}}, m_busy});
         chk("rvalid", {{(DATA_W-1){1'b0}}, rvalid}, {{(DATA_W-1){1'b0}}, m_rvalid});
         chk("rtag", {{(DATA_W-TAG_W){1'b0}}, rdata_tag}, {{(DATA_W-TAG_W){1'b0}}, m_rtag});
         chk("rdata", rdata_data & expand(m_rknown), m_rdata & expand(m_rknown));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle();
      rden = 0; raddr = '0; wren = 0; waddr = '0; wtag_en = 0; wbe = '0; wtag = '0; wdata = '0;
   endtask

   task automatic set_rd(input logic [ADDR_W-1:0] a);
      rden = 1; raddr = a;
   endtask

   task automatic set_wr(input logic [ADDR_W-1:0] a, input logic te, input logic [BE_W-1:0] be,
                         input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
      wren = 1; waddr = a; wtag_en = te; wbe = be; wtag = t; wdata = d;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Count rising edges from release until busy is observed low (bounded).
   task automatic measure_busy(input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (init_busy && n < 2000);
      chk(name, DATA_W'(n), DATA_W'(DEPTH));
   endtask

   // ---------------- directed stimulus ----------------
   logic [DATA_W-1:0] d1, d2, exp_d;
   logic [TAG_W-1:0]  t_same;

   initial begin
      idle();
      rst_n = 0;
      tick(); tick();
      chk("reset_busy", DATA_W'(init_busy), DATA_W'(1));
      chk("reset_rvalid", DATA_W'(rvalid), DATA_W'(0));
      chk("reset_rtag", DATA_W'(rdata_tag), DATA_W'(0));
      rst_n = 1;
      measure_busy("busy_len");
      chk("ready_state", DATA_W'(dbg_state), DATA_W'(2));
      tick();

      // Cleared tags at the ends and middle of the array.
      set_rd(0); tick();
      chk("rd0_valid", DATA_W'(rvalid), DATA_W'(1));
      chk("rd0_tag", DATA_W'(rdata_tag), DATA_W'(0));
      set_rd(255); tick();
      chk("rd255_tag", DATA_W'(rdata_tag), DATA_W'(0));
      set_rd(511); tick();
      chk("rd511_tag", DATA_W'(rdata_tag), DATA_W'(0));
      idle(); tick();
      chk("rd_stop_valid", DATA_W'(rvalid), DATA_W'(0));

      // Full write, read back, then hold for three idle cycles.
      set_wr(5, 1'b1, '1, 18'h2ABCD, '1); tick();
      idle(); set_rd(5); tick();
      chk("w5_valid", DATA_W'(rvalid), DATA_W'(1));
      chk("w5_tag", DATA_W'(rdata_tag), DATA_W'(18'h2ABCD));
      chk("w5_data", rdata_data, '1);
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_valid", DATA_W'(rvalid), DATA_W'(0));
         chk("hold_tag", DATA_W'(rdata_tag), DATA_W'(18'h2ABCD));
      end

      // Partial write: byte 0 only, tag untouched.
      set_wr(5, 1'b0, BE_W'(1), 18'h0, '0); tick();
      idle(); set_rd(5); tick();
      chk("part_tag", DATA_W'(rdata_tag), DATA_W'(18'h2ABCD));
      exp_d = {{(DATA_W-8){1'b1}}, 8'h00};
      chk("part_data", rdata_data, exp_d);

      // Same-index read and write in the same cycle.
      d1 = {16{32'h1111_1111}};
      d2 = {16{32'h2222_2222}};
      idle(); set_wr(7, 1'b1, '1, 18'h00011, d1); tick();
      idle(); set_wr(7, 1'b1, '1, 18'h00022, d2); set_rd(7); tick();
`ifdef SRAM_BYPASS_EN
      t_same = 18'h00022;
`else
      t_same = 18'h00011;
`endif
      chk("same_tag", DATA_W'(rdata_tag), DATA_W'(t_same));
      idle(); set_rd(7); tick();
      chk("after_same_tag", DATA_W'(rdata_tag), DATA_W'(18'h00022));
      chk("after_same_data", rdata_data, d2);

      // Same-index partial merge (alternate bytes, no tag write), then a
      // different-index read/write pair in one cycle.
      idle(); set_wr(7, 1'b0, {32{2'b01}}, 18'h3FFFF, '0); set_rd(7); tick();
      chk("merge_tag", DATA_W'(rdata_tag), DATA_W'(18'h00022));
      idle(); set_wr(8, 1'b1, '1, 18'h00888, d1); set_rd(5); tick();
      idle(); set_rd(8); tick();
      chk("indep_tag", DATA_W'(rdata_tag), DATA_W'(18'h00888));

      // Back-to-back reads with the expected tags queued.
      idle(); set_wr(1, 1'b1, '1, 18'h00101, {64{8'h01}}); tick();
      idle(); set_wr(2, 1'b1, '1, 18'h00202, {64{8'h02}}); tick();
      idle(); set_wr(3, 1'b1, '1, 18'h00303, {64{8'h03}}); tick();
      exp_q.push_back(18'h00101);
      exp_q.push_back(18'h00202);
      exp_q.push_back(18'h00303);
      idle(); set_rd(1); tick();
      for (int i = 2; i <= 4; i++) begin
         chk("b2b_valid", DATA_W'(rvalid), DATA_W'(1));
         chk("b2b_tag", DATA_W'(rdata_tag), DATA_W'(exp_q.pop_front()));
         idle();
         if (i <= 3) set_rd(ADDR_W'(i));
         tick();
      end
      chk("b2b_end_valid", DATA_W'(rvalid), DATA_W'(0));

      // Reset in the middle of the clear sweep, with requests held throughout.
      rst_n = 0; tick();
      rst_n = 1;
      set_wr(9, 1'b1, '1, 18'h3FFFF, '1); set_rd(9);
      repeat (300) @(posedge clk);
      tick();
      rst_n = 0; tick();
      chk("midinit_busy", DATA_W'(init_busy), DATA_W'(1));
      rst_n = 1;
      measure_busy("busy_len_restart");
      tick();
      idle(); set_rd(9); tick();
      chk("init_write_dropped", DATA_W'(rdata_tag), DATA_W'(0));
      idle(); set_rd(5); tick();
      chk("reclear_tag5", DATA_W'(rdata_tag), DATA_W'(0));
      idle(); tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_sram_array.md
# cache_sram_array

Parametrised dual-port tag/data storage for the cache controller; successor to the fixed 512×(18+512) array. Adds configurable depth and widths, per-byte data write enables, separate tag write enable, a read-valid strobe, and a sequenced post-reset tag clear. Sits between the cache controller FSM (lookup read port, fill/update write port) and nothing else. All storage is inferred registers/RAM on one clock.

## Interface
- ADDR_W, 9, index width; DEPTH = 2**ADDR_W entries
- TAG_W, 18, tag field width (includes valid/dirty bits as packed by the controller)
- DATA_W, 512, line width; must be a multiple of 8; BE_W = DATA_W/8 (derived, not overridable)

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- init_busy_o  out  1  high while the tag array is being cleared; ports ignored
- rden_i  in  1  read request
- raddr_i  in  ADDR_W  read index
- rvalid_o  out  1  one-cycle pulse: rdata_* updated this cycle
- rdata_tag_o  out  TAG_W  registered tag read data
- rdata_data_o  out  DATA_W  registered line read data
- wren_i  in  1  write request
- waddr_i  in  ADDR_W  write index
- wtag_en_i  in  1  write tag field when wren_i
- wbyte_en_i  in  BE_W  per-byte data write enable; bit k covers data[8k+7:8k]
- wdata_tag_i  in  TAG_W  tag write data
- wdata_data_i  in  DATA_W  line write data

## Operation
- States: RST (rst_n low), INIT, READY.
- RST: clear counter ← 0; init_busy_o=1, rvalid_o=0, rdata_tag_o=0, rdata_data_o=0. Data array not cleared (contents undefined until written).
- INIT: each cycle write tag_array[cnt] ← 0, cnt++; after writing entry DEPTH-1 go READY. rden_i/wren_i ignored (no array change besides clear, rvalid_o=0).
- rst_n low in any state, including mid-INIT → RST; INIT restarts from index 0.
- READY read: rden_i=1 → next cycle rdata_tag_o/rdata_data_o = entry[raddr_i], rvalid_o=1. rden_i=0 → rdata_* hold last value, rvalid_o=0.
- READY write: wren_i=1 → tag written iff wtag_en_i; data byte k written iff wbyte_en_i[k]; other bytes retain. wren_i=1 with wtag_en_i=0 and wbyte_en_i=0 is a legal no-op.
- Read and write to different indices same cycle: independent.
- Read and write to the same index same cycle: behaviour set by SRAM_BYPASS_EN (below). Array always ends holding new data.

## Timing
- Read latency 1 cycle (rden_i at edge N → data/rvalid_o valid after edge N+1); fully pipelined, one read per cycle.
- Write visible to a read issued the following cycle or later.
- init_busy_o deasserts exactly DEPTH cycles after first edge with rst_n=1 (512 for defaults); first accepted access on the edge where init_busy_o=0.
- No backpressure; requests while init_busy_o=1 are dropped, controller must wait.

## Configuration
- SRAM_BYPASS_EN defined: same-index read/write same cycle returns merged write data: tag = wdata_tag_i if wtag_en_i else old tag; byte k = wdata_data_i byte if wbyte_en_i[k] else old byte.
- Undefined: same-index read returns old (pre-write) contents, tag and data.

## Test plan
- Reset release → init_busy_o=1 for exactly 512 cycles, then 0; reads of indices 0, 255, 511 return tag 0x00000 with rvalid_o pulse 1 cycle later.
- Write idx 5, tag 0x2ABCD, data all 0xFF bytes, full enables; next cycle read idx 5 → tag 0x2ABCD, data all 0xFF; then rden_i=0 for 3 cycles → outputs hold, rvalid_o=0.
- Partial write idx 5, wtag_en_i=0, wbyte_en_i=0x...0001, byte0=0x00 → read gives tag 0x2ABCD, byte0 0x00, bytes 1..63 0xFF.
- Same-cycle read+write idx 7 (old tag 0x00011, new 0x00022, full enables) → 0x00022 with SRAM_BYPASS_EN, 0x00011 without; following read 0x00022 in both.
- rst_n low for 1 cycle at INIT count 300 → busy stays high, clears restart; busy drops 512 cycles after release; writes issued during INIT have no effect.
- Back-to-back reads idx 1,2,3 on consecutive cycles → three consecutive rvalid_o pulses with matching data in order.
